// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the rst_seq reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    DEBOUNCE = 2'd1,
    RELEASE  = 2'd2,
    RUN      = 2'd3
  } state_e;

  // Cause bit positions, relative to the first bit after the req causes.
  localparam int CAUSE_LOCK_OFS = 0;
  localparam int CAUSE_SW_OFS   = 1;
  localparam int CAUSE_WDT_OFS  = 2;

  function automatic int cnt_width(input int deb, input int gap, input int wdt);
    int m;
    m = (deb > gap) ? deb : gap;
    m = (wdt > m) ? wdt : m;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Two-flop synchroniser with asynchronous reset to a programmable value.
module rst_sync #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // Metastability chain; resets to the "request active" value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/rst_seq.sv
// rst_seq: debounced, staggered release of CHN reset domains with sticky cause capture.
// Optional watchdog: define RST_SEQ_WDT_EN to add the wdt_kick input and timeout cause.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int CHN = 4,
  parameter int SRC = 2,
  parameter int DEB = 500,
  parameter int GAP = 16,
  parameter int WDT = 32768
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [SRC-1:0] req,
  input  logic           lock,
  input  logic           sw_req,
`ifdef RST_SEQ_WDT_EN
  input  logic           wdt_kick,
`endif
  input  logic           cause_clr,
  output logic [CHN-1:0] rst_o,
  output logic           rdy,
  output logic [SRC+2:0] cause
);

  localparam int             CW        = cnt_width(DEB, GAP, WDT);
  localparam int             IW        = (CHN > 1) ? $clog2(CHN) : 1;
  localparam logic [CW-1:0]  DEB_LAST  = CW'(DEB - 1);
  localparam logic [CW-1:0]  GAP_LAST  = CW'(GAP - 1);
  localparam logic [IW-1:0]  LAST_IDX  = IW'(CHN - 1);
  localparam logic [IW:0]    SHAMT_OFS = (IW + 1)'(2);
  localparam logic [CHN-1:0] ONES      = {CHN{1'b1}};

  state_e         r_state;
  logic [CW-1:0]  r_cnt;
  logic [IW-1:0]  r_idx;
  logic [CHN-1:0] r_rst_o;
  logic           r_rdy;
  logic [SRC+2:0] r_cause;
  logic           r_lock_d;

  logic [SRC-1:0] w_req_s;
  logic           w_lock_s;
  logic           w_q;
  logic           w_active;
  logic           w_wdt_fire;
  logic [IW:0]    w_shamt;
  logic [SRC+2:0] w_cause_set;

  rst_sync #(.W(SRC), .RST_VAL({SRC{1'b1}})) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (req),
    .q   (w_req_s)
  );

  rst_sync #(.W(1), .RST_VAL(1'b0)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (lock),
    .q   (w_lock_s)
  );

  assign w_q      = ~|w_req_s & w_lock_s & ~sw_req;
  assign w_active = (r_state == RELEASE) | (r_state == RUN);
  // Bits 0..idx+1 are released once the next channel goes; shift amount is idx+2.
  assign w_shamt  = {1'b0, r_idx} + SHAMT_OFS;

`ifdef RST_SEQ_WDT_EN
  localparam logic [CW-1:0] WDT_LAST = CW'(WDT - 1);
  logic [CW-1:0] r_wdt;

  assign w_wdt_fire = (r_state == RUN) & ~wdt_kick & (r_wdt == WDT_LAST);

  // Watchdog counts only while settled in RUN; kick, timeout or exit clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdt <= '0;
    end else if ((r_state == RUN) & w_q & ~wdt_kick & ~w_wdt_fire) begin
      r_wdt <= r_wdt + 1'b1;
    end else begin
      r_wdt <= '0;
    end
  end
`else
  assign w_wdt_fire = 1'b0;
`endif

  // Causes are recorded once release has begun; glitches during debounce are filtered.
  always_comb begin
    w_cause_set = '0;
    if (w_active) begin
      w_cause_set[SRC-1:0]              = w_req_s;
      w_cause_set[SRC + CAUSE_LOCK_OFS] = r_lock_d & ~w_lock_s;
      w_cause_set[SRC + CAUSE_SW_OFS]   = sw_req;
    end else begin
      w_cause_set = '0;
    end
    w_cause_set[SRC + CAUSE_WDT_OFS] = w_wdt_fire;
  end

  // Sticky cause register; a new set beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cause  <= '0;
      r_lock_d <= 1'b0;
    end else begin
      r_lock_d <= w_lock_s;
      if (cause_clr) begin
        r_cause <= w_cause_set;
      end else begin
        r_cause <= r_cause | w_cause_set;
      end
    end
  end

  // Sequencer FSM with registered rst_o/rdy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= HOLD;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rst_o <= ONES;
      r_rdy   <= 1'b0;
    end else begin
      case (r_state)
        HOLD: begin
          r_rst_o <= ONES;
          r_rdy   <= 1'b0;
          r_idx   <= '0;
          r_cnt   <= '0;
          if (w_q) begin
            r_state <= DEBOUNCE;
          end else begin
            r_state <= HOLD;
          end
        end
        DEBOUNCE: begin
          if (!w_q) begin
            r_state <= HOLD;
            r_cnt   <= '0;
          end else if (r_cnt == DEB_LAST) begin
            r_state <= RELEASE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rst_o <= ONES << 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (!w_q) begin
            r_state <= HOLD;
            r_rst_o <= ONES;
            r_cnt   <= '0;
            r_idx   <= '0;
          end else if (r_idx == LAST_IDX) begin
            r_state <= RUN;
            r_rdy   <= 1'b1;
            r_cnt   <= '0;
          end else if (r_cnt == GAP_LAST) begin
            r_idx   <= r_idx + 1'b1;
            r_cnt   <= '0;
            r_rst_o <= ONES << w_shamt;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!w_q || w_wdt_fire) begin
            r_state <= HOLD;
            r_rst_o <= ONES;
            r_rdy   <= 1'b0;
          end else begin
            r_rst_o <= '0;
            r_rdy   <= 1'b1;
          end
          r_cnt <= '0;
          r_idx <= '0;
        end
        default: begin
          r_state <= HOLD;
          r_rst_o <= ONES;
          r_rdy   <= 1'b0;
          r_cnt   <= '0;
          r_idx   <= '0;
        end
      endcase
    end
  end

  assign rst_o = r_rst_o;
  assign rdy   = r_rdy;
  assign cause = r_cause;

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq: directed scenarios plus randomized disturbances
// checked against a quiet-run-length reference model.
module tb_rst_seq;

  localparam int CHN = 4;
  localparam int SRC = 2;
  localparam int DEB = 8;
  localparam int GAP = 4;
  localparam int WDT = 64;
  localparam int CBW = SRC + 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [SRC-1:0] req;
  logic           lock;
  logic           sw_req;
  logic           cause_clr;
  logic           wdt_kick;
  logic [CHN-1:0] rst_o;
  logic           rdy;
  logic [CBW-1:0] cause;

  int n_checks = 0;
  int n_pass   = 0;

  rst_seq #(.CHN(CHN), .SRC(SRC), .DEB(DEB), .GAP(GAP), .WDT(WDT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .sw_req    (sw_req),
`ifdef RST_SEQ_WDT_EN
    .wdt_kick  (wdt_kick),
`endif
    .cause_clr (cause_clr),
    .rst_o     (rst_o),
    .rdy       (rdy),
    .cause     (cause)
  );

  always #5 clk = ~clk;

  // Reference model: synchroniser delay line plus the length of the current quiet run.
  logic [SRC-1:0] m_req1, m_req2;
  logic           m_lock1, m_lock2, m_lock_prev;
  int             m_k;
  int             m_wdt;
  logic [CBW-1:0] m_cause;

  function automatic logic [CHN-1:0] exp_rst(input int k);
    logic [CHN-1:0] v;
    for (int i = 0; i < CHN; i++) v[i] = (k >= DEB + i * GAP + 1) ? 1'b0 : 1'b1;
    return v;
  endfunction

  function automatic logic exp_rdy(input int k);
    return (k >= DEB + (CHN - 1) * GAP + 2);
  endfunction

  task automatic model_reset();
    m_req1 = '1; m_req2 = '1;
    m_lock1 = 1'b0; m_lock2 = 1'b0; m_lock_prev = 1'b0;
    m_k = 0; m_wdt = 0; m_cause = '0;
  endtask

  task automatic model_edge();
    logic q, active, run, fire;
    logic [CBW-1:0] set;
    if (rst) begin
      model_reset();
      return;
    end
    q      = (m_req2 == '0) && m_lock2 && !sw_req;
    active = (m_k >= DEB + 1);
    run    = exp_rdy(m_k);
    fire   = 1'b0;
`ifdef RST_SEQ_WDT_EN
    fire  = run && !wdt_kick && (m_wdt == WDT - 1);
    m_wdt = (run && q && !wdt_kick && !fire) ? m_wdt + 1 : 0;
`endif
    set = '0;
    if (active) begin
      set[SRC-1:0] = m_req2;
      set[SRC]     = m_lock_prev && !m_lock2;
      set[SRC+1]   = sw_req;
    end
    set[SRC+2] = fire;
    m_cause = (cause_clr ? '0 : m_cause) | set;
    m_k = (q && !fire) ? ((m_k < 100000) ? m_k + 1 : m_k) : 0;
    m_lock_prev = m_lock2;
    m_req2 = m_req1; m_lock2 = m_lock1;
    m_req1 = req;    m_lock1 = lock;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check({tag, ":rst_o"}, 32'(rst_o), 32'(exp_rst(m_k)));
    check({tag, ":rdy"},   32'(rdy),   32'(exp_rdy(m_k)));
    check({tag, ":cause"}, 32'(cause), 32'(m_cause));
  endtask

  task automatic wait_rdy(input string tag);
    for (int i = 0; i < 200 && rdy !== 1'b1; i++) step(tag);
    check({tag, ":rdy_timeout"}, 32'(rdy), 32'd1);
  endtask

  initial begin
    rst = 1'b1; req = '0; lock = 1'b1; sw_req = 1'b0; cause_clr = 1'b0; wdt_kick = 1'b1;
    model_reset();
    #1;
    check("reset:rst_o", 32'(rst_o), 32'hF);
    check("reset:rdy",   32'(rdy),   32'd0);
    check("reset:cause", 32'(cause), 32'd0);
    step("reset"); step("reset");

    // Test 1: clean release, channels at 9/13/17/21 cycles after q rises.
    rst = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      step("t1");
      if (n == 10) check("t1:pre0", 32'(rst_o), 32'hF);
      if (n == 11) check("t1:ch0",  32'(rst_o), 32'hE);
      if (n == 15) check("t1:ch1",  32'(rst_o), 32'hC);
      if (n == 19) check("t1:ch2",  32'(rst_o), 32'h8);
      if (n == 23) check("t1:ch3",  32'(rst_o), 32'h0);
      if (n == 23) check("t1:rdy0", 32'(rdy),   32'd0);
      if (n == 24) check("t1:rdy1", 32'(rdy),   32'd1);
    end
    check("t1:cause", 32'(cause), 32'd0);

    // Test 2: req[1] glitch during debounce restarts the count, records nothing.
    rst = 1'b1; step("t2rst"); step("t2rst");
    rst = 1'b0;
    for (int n = 0; n < 5; n++) step("t2");
    req = 2'b10;
    for (int n = 0; n < 5; n++) step("t2g");
    req = 2'b00;
    step("t2");
    check("t2:held", 32'(rst_o), 32'hF);
    wait_rdy("t2w");
    check("t2:cause", 32'(cause), 32'd0);

    // Test 3: one-cycle lock drop in RUN.
    lock = 1'b0; step("t3");
    lock = 1'b1; step("t3");
    check("t3:still_run", 32'(rst_o), 32'h0);
    step("t3");
    check("t3:rst_o", 32'(rst_o), 32'hF);
    check("t3:rdy",   32'(rdy),   32'd0);
    check("t3:cause", 32'(cause), 32'h04);
    wait_rdy("t3w");

    // Test 4: sw_req at second channel release; clear coinciding with new causes.
    cause_clr = 1'b1; step("t4clr"); cause_clr = 1'b0;
    req = 2'b10; step("t4"); req = 2'b00;
    for (int i = 0; i < 100 && exp_rst(m_k) != 4'b1100; i++) step("t4");
    sw_req = 1'b1; cause_clr = 1'b1; step("t4sw");
    sw_req = 1'b0; cause_clr = 1'b0;
    check("t4:rst_o", 32'(rst_o), 32'hF);
    check("t4:cause", 32'(cause), 32'h08);
    wait_rdy("t4w");
    req = 2'b01; step("t4r"); req = 2'b00; step("t4r");
    cause_clr = 1'b1; step("t4c"); cause_clr = 1'b0;
    check("t4:cause2", 32'(cause), 32'h01);

`ifdef RST_SEQ_WDT_EN
    // Test 5: periodic kicks keep RUN, missing kicks trigger a watchdog reset.
    wait_rdy("t5w");
    wdt_kick = 1'b0;
    for (int p = 0; p < 4; p++) begin
      for (int n = 0; n < 59; n++) step("t5");
      wdt_kick = 1'b1; step("t5k"); wdt_kick = 1'b0;
    end
    check("t5:alive", 32'(rdy), 32'd1);
    for (int n = 1; n <= 65; n++) begin
      step("t5");
      if (n == 64) check("t5:rdy_pre", 32'(rdy), 32'd1);
    end
    check("t5:rst_o", 32'(rst_o), 32'hF);
    check("t5:cause", 32'(cause[SRC+2]), 32'd1);
    wdt_kick = 1'b1;
`endif

    // Test 6: asynchronous reset in the middle of RELEASE.
    for (int i = 0; i < 100 && exp_rst(m_k) != 4'b1100; i++) step("t6");
    #2 rst = 1'b1;
    #1;
    check("t6:rst_o", 32'(rst_o), 32'hF);
    check("t6:cause", 32'(cause), 32'd0);
    check("t6:rdy",   32'(rdy),   32'd0);
    model_reset();
    for (int n = 0; n < 3; n++) step("t6rst");
    rst = 1'b0;
    wait_rdy("t6w");

    // Randomized disturbances against the reference model.
    for (int n = 0; n < 1500; n++) begin
      req       = ($urandom_range(0, 149) == 0) ? SRC'($urandom_range(1, 3)) : '0;
      lock      = ($urandom_range(0, 249) != 0);
      sw_req    = ($urandom_range(0, 249) == 0);
      cause_clr = ($urandom_range(0, 39) == 0);
`ifdef RST_SEQ_WDT_EN
      wdt_kick  = ($urandom_range(0, 39) == 0);
`endif
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
